// File: rtl/avalon_mm_reg_manager.sv
// Avalon-MM slave front end: decodes commands against a register address map and
// forwards them as one-hot requests on a ready-handshake system bus, one at a time.
module avalon_mm_reg_manager #(
    parameter int unsigned                            REGISTERS_NUMBER = 4,
    parameter int unsigned                            ADDR_WIDTH       = 4,
    parameter logic [REGISTERS_NUMBER*ADDR_WIDTH-1:0] MEMORY_MAP       = {4'hC, 4'h8, 4'h4, 4'h0}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       avl_mm_addr,
    input  logic                        avl_mm_read,
    output logic                        avl_mm_readdatavalid,
    output logic [31:0]                 avl_mm_readdata,
    output logic [1:0]                  avl_mm_response,
    input  logic                        avl_mm_write,
    input  logic [31:0]                 avl_mm_writedata,
    input  logic [3:0]                  avl_mm_byteenable,
    output logic                        avl_mm_waitrequest,
    output logic [REGISTERS_NUMBER-1:0] sys_read_req,
    input  logic                        sys_read_ready,
    input  logic [31:0]                 sys_read_data,
    input  logic [1:0]                  sys_read_resp,
    input  logic                        sys_write_ready,
    output logic [REGISTERS_NUMBER-1:0] sys_write_req,
    output logic [3:0]                  sys_write_strb,
    output logic [31:0]                 sys_write_data
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [REGISTERS_NUMBER-1:0] w_onehot;
    logic                        w_mapped;
    logic                        w_complete;
    logic [REGISTERS_NUMBER-1:0] r_read_req;
    logic [REGISTERS_NUMBER-1:0] r_write_req;
    logic [31:0]                 r_write_data;
    logic [3:0]                  r_write_strb;
    logic [31:0]                 r_readdata;
    logic [1:0]                  r_response;
    logic                        r_readdatavalid;

    // First matching entry claims the address, so duplicates resolve to the lowest index.
    always_comb begin
        w_onehot = '0;
        w_mapped = 1'b0;
        for (int unsigned i = 0; i < REGISTERS_NUMBER; i++) begin
            if (!w_mapped && (avl_mm_addr == MEMORY_MAP[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_onehot[i] = 1'b1;
                w_mapped    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (avl_mm_write) begin
                    w_next = w_mapped ? WRITE : IDLE;
                end else if (avl_mm_read) begin
                    w_next = w_mapped ? READ : RESP;
                end
            end
            WRITE:   if (sys_write_ready) w_next = IDLE;
            READ:    if (sys_read_ready)  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A command completes when it is either retired on the system bus or dropped as unmapped.
    always_comb begin
        w_complete = 1'b0;
        unique case (r_state)
            IDLE:    w_complete = avl_mm_write ? !w_mapped : (avl_mm_read && !w_mapped);
            WRITE:   w_complete = sys_write_ready;
            READ:    w_complete = sys_read_ready;
            RESP:    w_complete = 1'b0;
            default: w_complete = 1'b0;
        endcase
        avl_mm_waitrequest = rst | ((avl_mm_read | avl_mm_write) & !w_complete);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_req      <= '0;
            r_write_req     <= '0;
            r_write_data    <= '0;
            r_write_strb    <= '0;
            r_readdata      <= '0;
            r_response      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= (w_next == RESP);
            unique case (r_state)
                IDLE: begin
                    if (avl_mm_write) begin
                        if (w_mapped) begin
                            r_write_req  <= w_onehot;
                            r_write_data <= avl_mm_writedata;
                            r_write_strb <= avl_mm_byteenable;
                        end
                    end else if (avl_mm_read) begin
                        if (w_mapped) begin
                            r_read_req <= w_onehot;
                        end else begin
                            r_readdata <= '0;
                            r_response <= 2'b11;
                        end
                    end
                end
                WRITE: begin
                    if (sys_write_ready) begin
                        r_write_req <= '0;
                    end
                end
                READ: begin
                    if (sys_read_ready) begin
                        r_read_req <= '0;
                        r_readdata <= sys_read_data;
                        r_response <= sys_read_resp;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sys_read_req         = r_read_req;
    assign sys_write_req        = r_write_req;
    assign sys_write_data       = r_write_data;
    assign sys_write_strb       = r_write_strb;
    assign avl_mm_readdata      = r_readdata;
    assign avl_mm_response      = r_response;
    assign avl_mm_readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_avalon_mm_reg_manager.sv
// Directed and randomized checks of avalon_mm_reg_manager against a transaction-level
// model of the default address map.
module tb_avalon_mm_reg_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  avl_mm_addr;
    logic        avl_mm_read;
    logic        avl_mm_readdatavalid;
    logic [31:0] avl_mm_readdata;
    logic [1:0]  avl_mm_response;
    logic        avl_mm_write;
    logic [31:0] avl_mm_writedata;
    logic [3:0]  avl_mm_byteenable;
    logic        avl_mm_waitrequest;
    logic [3:0]  sys_read_req;
    logic        sys_read_ready;
    logic [31:0] sys_read_data;
    logic [1:0]  sys_read_resp;
    logic        sys_write_ready;
    logic [3:0]  sys_write_req;
    logic [3:0]  sys_write_strb;
    logic [31:0] sys_write_data;

    int n_checks = 0;
    int n_fail   = 0;
    int map_addr [4] = '{0, 4, 8, 12};

    always #5 clk = ~clk;

    avalon_mm_reg_manager #(
        .REGISTERS_NUMBER(4),
        .ADDR_WIDTH(4),
        .MEMORY_MAP({4'hC, 4'h8, 4'h4, 4'h0})
    ) dut (
        .clk(clk),
        .rst(rst),
        .avl_mm_addr(avl_mm_addr),
        .avl_mm_read(avl_mm_read),
        .avl_mm_readdatavalid(avl_mm_readdatavalid),
        .avl_mm_readdata(avl_mm_readdata),
        .avl_mm_response(avl_mm_response),
        .avl_mm_write(avl_mm_write),
        .avl_mm_writedata(avl_mm_writedata),
        .avl_mm_byteenable(avl_mm_byteenable),
        .avl_mm_waitrequest(avl_mm_waitrequest),
        .sys_read_req(sys_read_req),
        .sys_read_ready(sys_read_ready),
        .sys_read_data(sys_read_data),
        .sys_read_resp(sys_read_resp),
        .sys_write_ready(sys_write_ready),
        .sys_write_req(sys_write_req),
        .sys_write_strb(sys_write_strb),
        .sys_write_data(sys_write_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_idx(input logic [3:0] a);
        for (int i = 0; i < 4; i++) begin
            if (32'(a) == map_addr[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_onehot(input int idx);
        return (idx < 0) ? 4'b0000 : 4'(1 << idx);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Master issues a write and holds it until waitrequest is low; the register stalls wt cycles.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be, input int wt);
        int         idx = exp_idx(a);
        logic [3:0] oh  = exp_onehot(idx);
        avl_mm_write      = 1'b1;
        avl_mm_addr       = a;
        avl_mm_writedata  = d;
        avl_mm_byteenable = be;
        sys_write_ready   = 1'($urandom_range(0, 1));
        #3;
        chk("wr_wait_accept", 32'(avl_mm_waitrequest), 32'(idx >= 0));
        next_cycle();
        if (idx < 0) begin
            avl_mm_write = 1'b0;
            #3;
            chk("wr_unmapped_req", 32'(sys_write_req), 32'(0));
        end else begin
            for (int k = 0; k <= wt; k++) begin
                sys_write_ready = (k == wt);
                #3;
                chk("wr_req", 32'(sys_write_req), 32'(oh));
                chk("wr_data", sys_write_data, d);
                chk("wr_strb", 32'(sys_write_strb), 32'(be));
                chk("wr_wait_hold", 32'(avl_mm_waitrequest), 32'(k != wt));
                next_cycle();
            end
            avl_mm_write    = 1'b0;
            sys_write_ready = 1'b0;
            #3;
            chk("wr_req_clear", 32'(sys_write_req), 32'(0));
            chk("wr_idle_wait", 32'(avl_mm_waitrequest), 32'(0));
        end
    endtask

    task automatic do_read(input logic [3:0] a, input int wt, input logic [31:0] rd, input logic [1:0] rr);
        int          idx = exp_idx(a);
        logic [3:0]  oh  = exp_onehot(idx);
        logic [31:0] e_data;
        logic [1:0]  e_resp;
        avl_mm_read    = 1'b1;
        avl_mm_addr    = a;
        sys_read_ready = 1'($urandom_range(0, 1));
        #3;
        chk("rd_wait_accept", 32'(avl_mm_waitrequest), 32'(idx >= 0));
        next_cycle();
        if (idx < 0) begin
            e_data = 32'h0;
            e_resp = 2'b11;
        end else begin
            e_data = rd;
            e_resp = rr;
            for (int k = 0; k <= wt; k++) begin
                sys_read_ready = (k == wt);
                sys_read_data  = (k == wt) ? rd : $urandom;
                sys_read_resp  = (k == wt) ? rr : 2'($urandom_range(0, 3));
                #3;
                chk("rd_req", 32'(sys_read_req), 32'(oh));
                chk("rd_wait_hold", 32'(avl_mm_waitrequest), 32'(k != wt));
                next_cycle();
            end
        end
        avl_mm_read    = 1'b0;
        sys_read_ready = 1'b0;
        #3;
        chk("rd_valid", 32'(avl_mm_readdatavalid), 32'(1));
        chk("rd_data", avl_mm_readdata, e_data);
        chk("rd_resp", 32'(avl_mm_response), 32'(e_resp));
        chk("rd_req_clear", 32'(sys_read_req), 32'(0));
        next_cycle();
        #3;
        chk("rd_valid_pulse", 32'(avl_mm_readdatavalid), 32'(0));
    endtask

    initial begin
        rst               = 1'b1;
        avl_mm_addr       = '0;
        avl_mm_read       = 1'b0;
        avl_mm_write      = 1'b0;
        avl_mm_writedata  = '0;
        avl_mm_byteenable = '0;
        sys_read_ready    = 1'b0;
        sys_read_data     = '0;
        sys_read_resp     = '0;
        sys_write_ready   = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        #3;
        chk("rst_wait", 32'(avl_mm_waitrequest), 32'(1));
        chk("rst_rreq", 32'(sys_read_req), 32'(0));
        chk("rst_wreq", 32'(sys_write_req), 32'(0));
        chk("rst_wdata", sys_write_data, 32'(0));
        chk("rst_wstrb", 32'(sys_write_strb), 32'(0));
        chk("rst_rdata", avl_mm_readdata, 32'(0));
        chk("rst_rvalid", 32'(avl_mm_readdatavalid), 32'(0));
        chk("rst_resp", 32'(avl_mm_response), 32'(0));
        rst = 1'b0;
        #1;
        chk("idle_wait", 32'(avl_mm_waitrequest), 32'(0));
        next_cycle();

        // Directed cases
        do_write(4'h4, 32'hDEADBEEF, 4'hF, 0);
        do_write(4'hC, 32'hCAFEF00D, 4'h5, 3);
        do_read(4'h8, 2, 32'h12345678, 2'b00);
        do_read(4'h3, 0, 32'h0, 2'b00);
        do_write(4'h3, 32'h11111111, 4'hF, 0);
        do_write(4'h0, 32'hA5A5A5A5, 4'h0, 1);

        // Reset while a read is outstanding
        avl_mm_read    = 1'b1;
        avl_mm_addr    = 4'h8;
        sys_read_ready = 1'b0;
        next_cycle();
        #3;
        chk("mid_rst_req", 32'(sys_read_req), 32'(4'b0100));
        rst = 1'b1;
        #1;
        chk("mid_rst_wait", 32'(avl_mm_waitrequest), 32'(1));
        next_cycle();
        rst         = 1'b0;
        avl_mm_read = 1'b0;
        #3;
        chk("mid_rst_req_clr", 32'(sys_read_req), 32'(0));
        chk("mid_rst_valid", 32'(avl_mm_readdatavalid), 32'(0));
        next_cycle();
        #3;
        chk("mid_rst_valid2", 32'(avl_mm_readdatavalid), 32'(0));
        next_cycle();
        do_read(4'h8, 0, 32'h0BADF00D, 2'b10);

        // Read and write together: write goes first, read stays stalled
        avl_mm_write      = 1'b1;
        avl_mm_read       = 1'b1;
        avl_mm_addr       = 4'h0;
        avl_mm_writedata  = 32'h5555AAAA;
        avl_mm_byteenable = 4'h3;
        sys_write_ready   = 1'b1;
        sys_read_ready    = 1'b1;
        sys_read_data     = 32'h87654321;
        sys_read_resp     = 2'b01;
        #3;
        chk("rw_wait0", 32'(avl_mm_waitrequest), 32'(1));
        next_cycle();
        #3;
        chk("rw_wreq", 32'(sys_write_req), 32'(4'b0001));
        chk("rw_rreq_none", 32'(sys_read_req), 32'(0));
        chk("rw_wait1", 32'(avl_mm_waitrequest), 32'(0));
        next_cycle();
        avl_mm_write = 1'b0;
        #3;
        chk("rw_wreq_clr", 32'(sys_write_req), 32'(0));
        chk("rw_wait2", 32'(avl_mm_waitrequest), 32'(1));
        next_cycle();
        #3;
        chk("rw_rreq", 32'(sys_read_req), 32'(4'b0001));
        chk("rw_wait3", 32'(avl_mm_waitrequest), 32'(0));
        next_cycle();
        avl_mm_read     = 1'b0;
        sys_read_ready  = 1'b0;
        sys_write_ready = 1'b0;
        #3;
        chk("rw_valid", 32'(avl_mm_readdatavalid), 32'(1));
        chk("rw_rdata", avl_mm_readdata, 32'h87654321);
        chk("rw_resp", 32'(avl_mm_response), 32'(2'b01));
        next_cycle();

        // Command presented during the response cycle is stalled, then accepted
        avl_mm_read = 1'b1;
        avl_mm_addr = 4'h3;
        #3;
        chk("b2b_wait0", 32'(avl_mm_waitrequest), 32'(0));
        next_cycle();
        avl_mm_read       = 1'b0;
        avl_mm_write      = 1'b1;
        avl_mm_addr       = 4'h0;
        avl_mm_writedata  = 32'h01020304;
        avl_mm_byteenable = 4'hF;
        sys_write_ready   = 1'b1;
        #3;
        chk("b2b_valid", 32'(avl_mm_readdatavalid), 32'(1));
        chk("b2b_resp", 32'(avl_mm_response), 32'(2'b11));
        chk("b2b_wait_resp", 32'(avl_mm_waitrequest), 32'(1));
        next_cycle();
        #3;
        chk("b2b_wait_idle", 32'(avl_mm_waitrequest), 32'(1));
        chk("b2b_wreq_none", 32'(sys_write_req), 32'(0));
        next_cycle();
        #3;
        chk("b2b_wreq", 32'(sys_write_req), 32'(4'b0001));
        chk("b2b_wait_done", 32'(avl_mm_waitrequest), 32'(0));
        next_cycle();
        avl_mm_write    = 1'b0;
        sys_write_ready = 1'b0;
        #3;
        chk("b2b_wreq_clr", 32'(sys_write_req), 32'(0));
        next_cycle();

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            logic [3:0] a;
            a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(map_addr[$urandom_range(0, 3)]);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
            end else begin
                do_read(a, int'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)));
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_mm_reg_manager.md
# avalon_mm_reg_manager

Avalon-MM slave front end for a memory-mapped register bank. It decodes each Avalon read or write against a parameterised address map and forwards it as a one-hot request on a simple ready-handshake system bus. It returns read data to the master through the pipelined `readdatavalid` protocol. One transaction is outstanding at a time. The block sits between the system interconnect and the controller's configuration/status registers.

## Interface
- `REGISTERS_NUMBER`, default 4: number of mapped registers; width of the one-hot request vectors.
- `ADDR_WIDTH`, default 4: Avalon address width.
- `MEMORY_MAP`, default {4'hC, 4'h8, 4'h4, 4'h0}: concatenation of `REGISTERS_NUMBER` addresses, each `ADDR_WIDTH` bits wide. Entry i (bits [i*ADDR_WIDTH +: ADDR_WIDTH]) is the address of register i.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `avl_mm_addr` in ADDR_WIDTH: byte address.
- `avl_mm_read` in 1: read command.
- `avl_mm_readdatavalid` out 1: read data valid; one-cycle pulse.
- `avl_mm_readdata` out 32: read data.
- `avl_mm_response` out 2: 00 OKAY, 11 DECODEERROR, or the `sys_read_resp` value passed through.
- `avl_mm_write` in 1: write command.
- `avl_mm_writedata` in 32: write data.
- `avl_mm_byteenable` in 4: byte lanes.
- `avl_mm_waitrequest` out 1: stall; the command completes on a cycle where this is low.
- `sys_read_req` out REGISTERS_NUMBER: one-hot read request.
- `sys_read_ready` in 1: read data/response valid; completes the system read.
- `sys_read_data` in 32: register read data.
- `sys_read_resp` in 2: register read response.
- `sys_write_ready` in 1: register accepts the write.
- `sys_write_req` out REGISTERS_NUMBER: one-hot write request.
- `sys_write_strb` out 4: byte strobes, copied from `avl_mm_byteenable`.
- `sys_write_data` out 32: write data.

## Operation
- Decode: `hit[i] = (avl_mm_addr == MEMORY_MAP[i])`. If duplicate entries exist, the lowest i wins. A miss means unmapped.
- The FSM has four states: IDLE, WRITE, READ, RESP.
- IDLE, `avl_mm_write` high, mapped:
  - Register the one-hot into `sys_write_req`, plus `sys_write_data` and `sys_write_strb`.
  - Go to WRITE.
  - `waitrequest` is 1.
- IDLE, `avl_mm_write` high, unmapped:
  - `waitrequest` is 0 and the write is discarded.
  - Stay in IDLE.
- IDLE, `avl_mm_read` high (write low), mapped:
  - Register the one-hot into `sys_read_req`.
  - Go to READ.
  - `waitrequest` is 1.
- IDLE, `avl_mm_read` high, unmapped:
  - `waitrequest` is 0.
  - Load readdata=0, response=11.
  - Go to RESP.
- Read and write high together: write has priority; the read stays stalled.
- WRITE: hold the request, data and strobe until `sys_write_ready` = 1. On that cycle:
  - `waitrequest` = 0.
  - The request clears at the next edge.
  - Go to IDLE.
- READ: hold `sys_read_req` until `sys_read_ready` = 1. On that cycle:
  - Capture `sys_read_data` and `sys_read_resp`.
  - `waitrequest` = 0.
  - Clear the request.
  - Go to RESP.
- RESP:
  - `avl_mm_readdatavalid` = 1 for exactly one cycle, with the captured readdata/response.
  - Go to IDLE.
  - `waitrequest` = 1 for any command presented in this cycle.
- `waitrequest` is combinational:
  - 1 when read or write is asserted and the command does not complete this cycle.
  - 0 when no command is presented.
  - Forced to 1 while `rst` is high.
- A zero byteenable write is still forwarded, with strb=0.

## Timing
- Reset values:
  - All request vectors, `sys_write_data`, `sys_write_strb`, `avl_mm_readdata` and `avl_mm_readdatavalid` are 0.
  - `avl_mm_response` is 00 and the FSM is in IDLE.
  - `avl_mm_waitrequest` is 1.
- Mapped write: command at cycle 0, `sys_write_req` visible at cycle 1. With ready already high, `waitrequest` is low at cycle 1 (two-cycle write). Each ready-low cycle adds one cycle.
- Mapped read: command at cycle 0, `sys_read_req` at cycle 1. With ready high, `waitrequest` is low at cycle 1 and `readdatavalid` is high at cycle 2.
- Unmapped read: `waitrequest` is low at cycle 0 and `readdatavalid` is high at cycle 1. No system request is issued.
- `sys_*_ready` is sampled only in the matching state and ignored elsewhere.
- Reset mid-transaction: requests drop at the next edge, no `readdatavalid` is produced, and the FSM goes to IDLE.
- Back-to-back: a new command is accepted into IDLE no earlier than the cycle after completion (after RESP for reads).

## Test plan
- Write addr 0x4, data 0xDEADBEEF, be 0xF, `sys_write_ready`=1 -> `sys_write_req`=0010 for one cycle with data 0xDEADBEEF, strb F; `waitrequest` high 1 cycle then low.
- Write addr 0xC with `sys_write_ready` low for 3 cycles -> `sys_write_req`=1000 held 4 cycles; `waitrequest` low only on the ready cycle.
- Read addr 0x8, `sys_read_ready` after 2 cycles with data 0x12345678, resp 00 -> `sys_read_req`=0100 until ready; `readdatavalid` one cycle later with 0x12345678, 00.
- Read unmapped addr 0x3 -> no `sys_read_req`; `readdatavalid` next cycle with data 0, response 11. Write to 0x3 -> no `sys_write_req`, `waitrequest` 0.
- Assert `rst` while in READ -> `sys_read_req`=0 next edge, no `readdatavalid`, `waitrequest` 1 during reset; next read completes normally.
- Read and write both asserted at 0x0 -> write is issued first (`sys_write_req`=0001), then the read (`sys_read_req`=0001).
